// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Valid/ready on both sides, bubble collapsing, synchronous flush and an
// occupancy counter. out_ready -> in_ready is a combinational ready chain
// through all stages (intended for DEPTH <= 8).
module dff_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] r_c;
    logic             rdy_acc_c;
    logic             in_xfer_c;
    logic             out_xfer_c;

    // Per-stage ready: a stage can load if it or any stage ahead of it has room,
    // or the output stage is draining this cycle.
    always_comb begin
        r_c       = '0;
        rdy_acc_c = out_ready_i;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            rdy_acc_c = rdy_acc_c | ~v_q[i];
            r_c[i]    = rdy_acc_c;
        end
    end

    assign in_ready_o = r_c[0] & ~flush_i & ~rst_i;
    assign in_xfer_c  = in_valid_i & in_ready_o;
    assign out_xfer_c = v_q[DEPTH-1] & out_ready_i;

    assign out_valid_o = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];
    assign count_o     = count_q;

    // Next-state: advance every ready stage from its upstream neighbour; flush clears valids.
    always_comb begin
        v_d     = v_q;
        d_d     = d_q;
        count_d = count_q + CW'(in_xfer_c) - CW'(out_xfer_c);

        if (r_c[0]) begin
            v_d[0] = in_valid_i;
            if (in_valid_i) begin
                d_d[0] = in_data_i;
            end
        end

        for (int i = 1; i < int'(DEPTH); i++) begin
            if (r_c[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end

        if (flush_i) begin
            v_d     = '0;
            d_d     = d_q;
            count_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= RST_VAL;
            end
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Testbench for dff_pipe: directed scenarios plus random traffic checked
// against a timestamped FIFO model of the pipeline.
module tb_dff_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [WIDTH-1:0] RST_VAL = 8'h3C;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [$clog2(DEPTH+1)-1:0] count;

    dff_pipe #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: in-flight items in order, each with the earliest edge at which it
    // can sit in the output stage (DEPTH-1 edges after accept, or the edge its
    // predecessor leaves, whichever is later).
    typedef struct {
        logic [WIDTH-1:0] data;
        int               arr;
    } item_t;

    item_t q[$];
    int    edge_n;
    int    n_tests;
    int    n_fail;
    logic  acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance both.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic fl, input logic rs, output logic accepted);
        logic exp_ir;
        logic exp_ov;
        logic out_x;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        exp_ir = !rs && !fl && ((q.size() < int'(DEPTH)) || ordy);
        exp_ov = (q.size() > 0) && (q[0].arr <= edge_n);
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check_eq("out_data", 32'(out_data), 32'(q[0].data));
        end
        check_eq("count", 32'(count), 32'(q.size()));
        accepted = iv && exp_ir;
        out_x    = exp_ov && ordy;
        @(posedge clk);
        edge_n++;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (out_x) begin
                void'(q.pop_front());
                if (q.size() > 0 && q[0].arr < edge_n) q[0].arr = edge_n;
            end
            if (accepted) begin
                q.push_back('{data: id, arr: edge_n + int'(DEPTH) - 1});
            end
        end
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        edge_n    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with junk input offered.
        for (int i = 0; i < 2; i++) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, acc);
        check_eq("rst_data", 32'(out_data), 32'(RST_VAL));
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        check_eq("rst_data_idle", 32'(out_data), 32'(RST_VAL));

        // Streaming 0x01..0x08.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure: 0x10..0x13 fill, 0x14 stalls, then drain.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, acc);
        check_eq("bp_full", 32'(count), 32'(DEPTH));
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1'b1, 8'h14, 1'b1, 1'b0, 1'b0, acc);
        check_eq("bp_0x14_accepted", 32'(acc), 32'(1));
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Bubble collapse.
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        check_eq("bubble_count", 32'(count), 32'(2));
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Flush with three items in flight; 0x77 must be refused.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, acc);
        check_eq("flush_count", 32'(count), 32'(0));
        check_eq("flush_out_valid", 32'(out_valid), 32'(0));
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Full pass-through.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hF0 + i), 1'b1, 1'b0, 1'b0, acc);
        check_eq("full_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 65), 8'($urandom), 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 149) == 0), acc);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready handshaking on both sides, per-stage valid tracking, bubble collapsing, synchronous flush and an occupancy count. Used wherever a datapath needs a fixed nominal delay that must also tolerate downstream backpressure without losing or duplicating data.

## Interface

- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- RST_VAL, 0, value loaded into every stage's data register on reset
- clk  input  1  single clock; all state changes on posedge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all in-flight data
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  write data
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  data register of stage DEPTH-1
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation

- One clock; reset is synchronous and active-high on rst.
- Stage i holds v[i] and d[i]; stage 0 is input side, stage DEPTH-1 drives out_valid = v[DEPTH-1] and out_data = d[DEPTH-1].
- Per-stage ready: r[DEPTH-1] = !v[DEPTH-1] | out_ready; r[i] = !v[i] | r[i+1]. in_ready = r[0] & !flush & !rst.
- Transfer into stage i on a cycle when r[i] = 1: from stage i-1 (or the input for i = 0). Stage i loads v[i] <= v[i-1] (or in_valid) and loads d[i] only if that source is valid; otherwise d[i] holds its value.
- Bubble collapse: an empty stage always accepts from upstream, so valid items advance toward the output whenever slots ahead are free, even while out_ready = 0.
- Ordering is strict FIFO; no item is dropped or duplicated except by flush or rst.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Flush: at the next edge all v[i] <= 0 and count <= 0. d[i] holds. During the flush cycle in_ready = 0 and no input is accepted. out_valid still reflects v[DEPTH-1], but any output transfer in that cycle counts as completed.
- count = popcount(v) as a register: +1 on input transfer, -1 on output transfer, unchanged on both or neither. Range 0..DEPTH.
- Reset (rst = 1 at posedge): all v = 0, all d = RST_VAL, count = 0. in_ready = 0 while rst is high; out_valid = 0 from the first edge after rst asserts.
- rst has priority over flush; flush has priority over transfers.

## Timing

- Latency with no stalls: an item accepted at edge N is presented on out_data with out_valid = 1 after edge N+DEPTH-1. That is DEPTH register stages, so it is visible in cycle N+DEPTH relative to the accepting cycle.
- Throughput: 1 item/cycle sustained when out_ready = 1.
- Full (count = DEPTH) with out_ready = 1: in_ready = 1 through the combinational r chain, so simultaneous accept and emit occurs and count is unchanged.
- Full with out_ready = 0: in_ready = 0.
- The combinational path out_ready -> in_ready spans DEPTH stages. This is accepted for DEPTH <= 8; larger DEPTH needs a skid stage and is out of scope.
- rst or flush mid-operation: clears occupancy at that edge. No partial output is produced afterwards.
- count never wraps; width $clog2(DEPTH+1) covers DEPTH exactly (e.g. DEPTH = 4 -> 3 bits).

## Test plan

- Reset: hold rst = 1 for 2 cycles with in_valid = 1, in_data = 0xFF. Required: in_ready = 0, out_valid = 0, out_data = RST_VAL, count = 0, and 0xFF never emerges.
- Streaming (WIDTH = 8, DEPTH = 4, out_ready = 1): send 0x01..0x08 back to back. Required: 0x01 valid 4 cycles after its accept, then one value per cycle in order; count holds at 4 during steady state.
- Backpressure: with out_ready = 0, send 0x10..0x14. Required: the first 4 are accepted, in_ready drops with count = 4, and 0x14 is stalled. Raising out_ready = 1 yields 0x10..0x14 in order with no duplicates.
- Bubble collapse: with out_ready = 0, send 0xA1, idle 3 cycles, then send 0xA2. Required: 0xA1 sits at output stage, 0xA2 sits directly behind it, count = 2. Raising out_ready emits 0xA1 then 0xA2 on consecutive cycles.
- Flush: with 3 items in flight, assert flush for 1 cycle with in_valid = 1, in_data = 0x77. Required: next cycle count = 0 and out_valid = 0, and 0x77 is not accepted. 0x55 sent afterwards appears after DEPTH cycles.
- Full pass-through: at count = 4 with out_ready = 1 and in_valid = 1 for 6 cycles. Required: in_ready = 1 every cycle, one emit per cycle, count stays 4.
